// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: serially shifts up to 16 pattern bits into a 4-bit display
// register at a divided tick rate. It then holds for HOLD_TICKS ticks and
// pulses done_o.
// Optional feature macro: SHIFT_SEQ_CLEAR_EN. When it is defined, sr_o is
// cleared on start acceptance. When it is undefined, new bits shift in on top
// of the old sr_o contents.
module shift_seq_ctrl #(
    parameter int unsigned TICK_CNT   = 12500000,
    parameter int unsigned DIV_W      = 24,
    parameter int unsigned HOLD_TICKS = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_i,
    input  logic        abort_i,
    input  logic [15:0] pattern_i,
    input  logic [4:0]  len_i,
    input  logic        dir_i,
    output logic [3:0]  sr_o,
    output logic        ser_o,
    output logic        tick_o,
    output logic        busy_o,
    output logic        done_o
);

    localparam int unsigned HOLD_W = (HOLD_TICKS < 2) ? 1 : $clog2(HOLD_TICKS + 1);
    // Divider value one cycle before the tick cycle; tick_o is registered from it.
    localparam logic [DIV_W-1:0] DIV_PRE = DIV_W'(TICK_CNT - 2);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t            state;
    logic [DIV_W-1:0]  div_q;
    logic [15:0]       pat_q;
    logic              dir_q;
    logic [4:0]        rem_q;
    logic [HOLD_W-1:0] hold_q;

    logic [4:0]        len_clip;
    logic              shift_bit;

    // Requested length clipped to the 16-bit pattern width.
    assign len_clip  = (len_i > 5'd16) ? 5'd16 : len_i;
    // Bit that leaves the captured pattern on the next shift.
    assign shift_bit = dir_q ? pat_q[0] : pat_q[15];

    // Sequencer: state, tick divider, shifting datapath and registered strobes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            div_q  <= '0;
            pat_q  <= '0;
            dir_q  <= 1'b0;
            rem_q  <= '0;
            hold_q <= '0;
            sr_o   <= '0;
            ser_o  <= 1'b0;
            tick_o <= 1'b0;
            busy_o <= 1'b0;
            done_o <= 1'b0;
        end else begin
            done_o <= 1'b0;
            if (state == IDLE) begin
                if (start_i && !abort_i) begin
                    pat_q  <= pattern_i;
                    dir_q  <= dir_i;
                    rem_q  <= len_clip;
                    hold_q <= HOLD_W'(HOLD_TICKS);
                    div_q  <= '0;
                    tick_o <= 1'b0;
                    ser_o  <= 1'b0;
                    busy_o <= 1'b1;
`ifdef SHIFT_SEQ_CLEAR_EN
                    sr_o   <= '0;
`endif
                    state  <= (len_clip == 5'd0) ? HOLD : SHIFT;
                end
            end else if (abort_i) begin
                // Abort freezes sr_o and drops back to idle without done.
                state  <= IDLE;
                busy_o <= 1'b0;
                div_q  <= '0;
                tick_o <= 1'b0;
                ser_o  <= 1'b0;
            end else if (tick_o) begin
                div_q  <= '0;
                tick_o <= 1'b0;
                ser_o  <= 1'b0;
                if (state == SHIFT) begin
                    pat_q <= dir_q ? {1'b0, pat_q[15:1]} : {pat_q[14:0], 1'b0};
                    sr_o  <= dir_q ? {shift_bit, sr_o[3:1]} : {sr_o[2:0], shift_bit};
                    rem_q <= rem_q - 5'd1;
                    if (rem_q == 5'd1) begin
                        if (HOLD_TICKS == 0) begin
                            state  <= IDLE;
                            busy_o <= 1'b0;
                            done_o <= 1'b1;
                        end else begin
                            state <= HOLD;
                        end
                    end
                end else if (hold_q <= HOLD_W'(1)) begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                    done_o <= 1'b1;
                end else begin
                    hold_q <= hold_q - HOLD_W'(1);
                end
            end else if (state == HOLD && hold_q == '0) begin
                // Zero length with no hold: finish one edge after start.
                state  <= IDLE;
                busy_o <= 1'b0;
                done_o <= 1'b1;
                div_q  <= '0;
            end else begin
                div_q <= div_q + DIV_W'(1);
                if (div_q == DIV_PRE) begin
                    tick_o <= 1'b1;
                    ser_o  <= (state == SHIFT) ? shift_bit : 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Scoreboard bench for shift_seq_ctrl. The driver pushes the expected tick and
// done events of each sequence. The monitor pops and compares them at negedge.
module tb_shift_seq_ctrl;

    localparam int unsigned T     = 4;
    localparam int unsigned DIV_W = 8;
    localparam int unsigned H     = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_i, abort_i, dir_i;
    logic [15:0] pattern_i;
    logic [4:0]  len_i;
    logic [3:0]  sr_o;
    logic        ser_o, tick_o, busy_o, done_o;

    shift_seq_ctrl #(.TICK_CNT(T), .DIV_W(DIV_W), .HOLD_TICKS(H)) dut (
        .clk(clk), .reset(reset), .start_i(start_i), .abort_i(abort_i),
        .pattern_i(pattern_i), .len_i(len_i), .dir_i(dir_i),
        .sr_o(sr_o), .ser_o(ser_o), .tick_o(tick_o), .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        is_done;
        logic        ser;
        logic [3:0]  sr;
        logic [31:0] cyc;
    } ev_t;

    ev_t         exp_q[$];
    ev_t         mon_ev;
    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    int          tick_seen = 0;
    logic [3:0]  model_sr = 4'h0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: every tick/done the DUT presents must match the head of the queue.
    always @(negedge clk) begin
        if (!reset) begin
            if (tick_o) tick_seen++;
            else check("ser_idle", 32'(ser_o), 32'd0);
            if (tick_o || done_o) begin
                if (exp_q.size() == 0) begin
                    check("spurious_evt", 32'({tick_o, done_o}), 32'd0);
                end else begin
                    mon_ev = exp_q.pop_front();
                    check("evt_kind", 32'(done_o), 32'(mon_ev.is_done));
                    check("evt_cycle", cyc, mon_ev.cyc);
                    check("evt_sr", 32'(sr_o), 32'(mon_ev.sr));
                    if (mon_ev.is_done) check("busy_at_done", 32'(busy_o), 32'd0);
                    else check("evt_ser", 32'(ser_o), 32'(mon_ev.ser));
                end
            end
        end
    end

    task automatic wait_cyc(input int unsigned target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Start a sequence and queue its expected events; abort_at>0 means abort before edge k+abort_at.
    task automatic issue(input logic [15:0] p, input logic [4:0] l, input logic d,
                         input int unsigned abort_at, output int unsigned k);
        int unsigned L;
        int unsigned lim;
        int unsigned dc;
        logic [3:0]  s;
        logic        b;
        ev_t         ev;
        @(negedge clk);
        pattern_i = p; len_i = l; dir_i = d; start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        k = cyc;
        tick_seen = 0;
        L = (l > 5'd16) ? 16 : 32'(l);
        s = model_sr;
`ifdef SHIFT_SEQ_CLEAR_EN
        s = 4'h0;
`endif
        check("busy_after_start", 32'(busy_o), 32'd1);
        check("sr_at_start", 32'(sr_o), 32'(s));
        lim = (abort_at > 0) ? k + abort_at - 1 : 32'hFFFF_FFFF;
        for (int unsigned n = 1; n <= L + H; n++) begin
            ev.cyc = k + n * T - 1;
            if (ev.cyc > lim) break;
            b = 1'b0;
            if (n <= L) b = d ? p[n-1] : p[16-n];
            ev.is_done = 1'b0;
            ev.ser = b;
            ev.sr = s;
            exp_q.push_back(ev);
            if (n <= L && ev.cyc + 1 <= lim) s = d ? {b, s[3:1]} : {s[2:0], b};
        end
        dc = (L == 0 && H == 0) ? k + 1 : k + (L + H) * T;
        if (dc <= lim) begin
            ev.is_done = 1'b1; ev.ser = 1'b0; ev.sr = s; ev.cyc = dc;
            exp_q.push_back(ev);
        end
        model_sr = s;
    endtask

    // Wait for the queue to empty, then watch for late events (e.g. a queued start).
    task automatic drain(input string tag);
        int guard = 0;
        while (exp_q.size() != 0 && guard < 2000) begin
            @(posedge clk);
            guard++;
        end
        check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        repeat (2 * T + 2) @(posedge clk);
        #1;
        check({tag, "_idle_busy"}, 32'(busy_o), 32'd0);
    endtask

    task automatic run_txn(input string tag, input logic [15:0] p, input logic [4:0] l,
                           input logic d, input int unsigned abort_at, input logic stray);
        int unsigned k;
        issue(p, l, d, abort_at, k);
        if (stray) begin
            wait_cyc(k + 5);
            start_i = 1'b1; pattern_i = 16'($urandom); len_i = 5'd16; dir_i = ~d;
            @(posedge clk);
            #1;
            start_i = 1'b0;
        end
        if (abort_at > 0) begin
            wait_cyc(k + abort_at - 1);
            abort_i = 1'b1;
            @(posedge clk);
            #1;
            abort_i = 1'b0;
            check({tag, "_abort_busy"}, 32'(busy_o), 32'd0);
            check({tag, "_abort_sr"}, 32'(sr_o), 32'(model_sr));
        end
        drain(tag);
    endtask

    initial begin
        int unsigned k;
        logic [15:0] p;
        logic [4:0]  l;
        logic [3:0]  sr_before;
        reset = 1'b1; start_i = 1'b0; abort_i = 1'b0; dir_i = 1'b0;
        pattern_i = 16'h0; len_i = 5'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_sr", 32'(sr_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_tick", 32'(tick_o), 32'd0);
        check("rst_ser", 32'(ser_o), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        run_txn("msb", 16'hA000, 5'd4, 1'b0, 0, 1'b0);
        check("msb_sr", 32'(sr_o), 32'h0000_000A);
        check("msb_ticks", 32'(tick_seen), 32'd6);

        run_txn("lsb", 16'h0003, 5'd4, 1'b1, 0, 1'b0);
        check("lsb_sr", 32'(sr_o), 32'h0000_0003);
        check("lsb_ticks", 32'(tick_seen), 32'd6);

        run_txn("fill", 16'hFFFF, 5'd4, 1'b0, 0, 1'b0);
        check("fill_sr", 32'(sr_o), 32'h0000_000F);
        run_txn("clr", 16'h0000, 5'd2, 1'b0, 0, 1'b0);
`ifdef SHIFT_SEQ_CLEAR_EN
        check("clr_sr", 32'(sr_o), 32'h0000_0000);
`else
        check("clr_sr", 32'(sr_o), 32'h0000_000C);
`endif

        sr_before = sr_o;
        run_txn("len0", 16'h1234, 5'd0, 1'b0, 0, 1'b0);
        check("len0_sr", 32'(sr_o), 32'(sr_before));
        check("len0_ticks", 32'(tick_seen), 32'd2);

        p = 16'($urandom);
        run_txn("len20", p, 5'd20, 1'b0, 0, 1'b0);
        check("len20_sr", 32'(sr_o), 32'(p[3:0]));
        check("len20_ticks", 32'(tick_seen), 32'd18);

        run_txn("abort", 16'hA000, 5'd4, 1'b0, 9, 1'b1);
        check("abort_ticks", 32'(tick_seen), 32'd2);

        // Abort in idle blocks a simultaneous start.
        @(negedge clk);
        start_i = 1'b1; abort_i = 1'b1; len_i = 5'd4;
        @(posedge clk);
        #1;
        start_i = 1'b0; abort_i = 1'b0;
        check("idle_abort_blocks", 32'(busy_o), 32'd0);

        // Reset in the middle of HOLD.
        issue(16'hA000, 5'd4, 1'b0, 0, k);
        wait_cyc(k + 18);
        #2;
        reset = 1'b1;
        #1;
        exp_q.delete();
        model_sr = 4'h0;
        check("mid_rst_sr", 32'(sr_o), 32'd0);
        check("mid_rst_busy", 32'(busy_o), 32'd0);
        check("mid_rst_tick", 32'(tick_o), 32'd0);
        check("mid_rst_ser", 32'(ser_o), 32'd0);
        check("mid_rst_done", 32'(done_o), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        run_txn("after_rst", 16'hA000, 5'd4, 1'b0, 0, 1'b0);
        check("after_rst_sr", 32'(sr_o), 32'h0000_000A);

        for (int i = 0; i < 20; i++) begin
            p = 16'($urandom);
            l = 5'($urandom_range(0, 20));
            run_txn("rand", p, l, 1'($urandom_range(0, 1)), 0, 1'b0);
            check("rand_ticks", 32'(tick_seen), (l > 5'd16) ? 32'd18 : 32'(l) + 32'(H));
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
